mult_unit: RTL and testbench

Iterative unsigned multiplier with architectural HI/LO registers, downstream of the instruction decoder. It executes `multu` (decoder `alucontrol` 3'b100) over WIDTH clock cycles using radix-2 shift-add and holds the 2·WIDTH-bit product in HI/LO. It serves `mfhi`/`mflo` (`alucontrol` 3'b011) through a read mux. While a multiply is in flight, it raises a stall so the core does not read stale HI/LO.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult_step.sv | 32 +++
 rtl/mult_unit.sv | 102 ++++++++++
 tb/tb_mult_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared encodings and defaults for the iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MULT_WIDTH = 32;

  // Decoder alucontrol encodings shared with the core glue
  localparam logic [2:0] ALU_MULTU  = 3'b100;
  localparam logic [2:0] ALU_MFHILO = 3'b011;

  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

endpackage : mult_pkg

`default_nettype wire

// File: rtl/mult_step.sv
// ============================================================================
// Module      : mult_step
// Description : One radix-2 shift-add step of the multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_addend;

  assign w_addend = acc_lo[0] ? mcand : '0;
  assign w_sum    = {1'b0, acc_hi} + {1'b0, w_addend};

  // The carry lands in the top bit of the shifted accumulator
  assign nxt_hi = w_sum[WIDTH:1];
  assign nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};

endmodule : mult_step

`default_nettype wire

// File: rtl/mult_unit.sv
// ============================================================================
// Module      : mult_unit
// Description : Iterative unsigned multiplier with architectural HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned    c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(WIDTH - 1);
  localparam logic [0:0]     c_ST_IDLE = IDLE;
  localparam logic [0:0]     c_ST_RUN  = RUN;

  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic [WIDTH-1:0]   w_nxt_hi;
  logic [WIDTH-1:0]   w_nxt_lo;
  logic               w_last;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_hi (r_acc_hi),
    .acc_lo (r_acc_lo),
    .mcand  (r_mcand),
    .nxt_hi (w_nxt_hi),
    .nxt_lo (w_nxt_lo)
  );

  assign w_last = (r_state == c_ST_RUN) && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_ST_IDLE;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Completion commits even when a new start arrives on the same edge
      if (w_last) begin
        r_hi   <= w_nxt_hi;
        r_lo   <= w_nxt_lo;
        r_done <= 1'b1;
      end
      if (start) begin
        r_state  <= c_ST_RUN;
        r_acc_hi <= '0;
        r_acc_lo <= b;
        r_mcand  <= a;
        r_cnt    <= c_CNT_MAX;
      end else if (r_state == c_ST_RUN) begin
        r_acc_hi <= w_nxt_hi;
        r_acc_lo <= w_nxt_lo;
        r_cnt    <= r_cnt - 1'b1;
        if (w_last) begin
          r_state <= c_ST_IDLE;
        end
      end
    end
  end

  assign busy   = (r_state == c_ST_RUN);
  assign stall  = busy & rd_req;
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = rd_hi ? r_hi : r_lo;

endmodule : mult_unit

`default_nettype wire

// File: tb/tb_mult_unit.sv
// ============================================================================
// Module      : tb_mult_unit
// Description : Directed self-checking bench for mult_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             rd_hi;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_checks = 0;
  int n_fails  = 0;

  mult_unit #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .rd_req (rd_req),
    .rd_hi  (rd_hi),
    .result (result),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a multiply, then count busy cycles and done pulses until idle
  task automatic run_mul(input string tag, input logic [WIDTH-1:0] op_a,
                         input logic [WIDTH-1:0] op_b,
                         input logic [WIDTH-1:0] exp_hi,
                         input logic [WIDTH-1:0] exp_lo);
    int n_busy;
    start = 1'b1; a = op_a; b = op_b;
    tick();
    start = 1'b0;
    n_busy = 0;
    while (busy && n_busy < 200) begin
      n_busy++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n_busy), 64'd32);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    chk({tag, "_done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int n_done;
    reset = 1'b0; start = 1'b0; a = '0; b = '0; rd_req = 1'b0; rd_hi = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    tick();

    // Idle reads return immediately
    rd_req = 1'b1; rd_hi = 1'b0; #1;
    chk("idle_mflo", 64'(result), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
    rd_hi = 1'b1; #1;
    chk("idle_mfhi", 64'(result), 64'd0);
    rd_req = 1'b0;
    tick();

    run_mul("basic", 32'd3, 32'd5, 32'd0, 32'd15);
    rd_req = 1'b1; rd_hi = 1'b0; #1;
    chk("basic_mflo", 64'(result), 64'd15);
    rd_req = 1'b0;

    run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mul("carry", 32'h8000_0000, 32'd2, 32'd1, 32'd0);
    run_mul("zero", 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);

    // mfhi stalled behind a multiply
    start = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000;
    tick();
    start = 1'b0; rd_req = 1'b1; rd_hi = 1'b1; #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      tick();
    end
    chk("stall_cycles", 64'(n), 64'd32);
    chk("stall_mfhi", 64'(result), 64'd1);
    rd_hi = 1'b0; #1;
    chk("stall_mflo", 64'(result), 64'd0);
    rd_req = 1'b0;
    tick();

    // Restart: the second multiply wins, the first is never committed
    start = 1'b1; a = 32'd7; b = 32'd9;
    tick();
    start = 1'b0;
    n_done = 0;
    repeat (9) begin
      if (done) n_done++;
      tick();
    end
    start = 1'b1; a = 32'd2; b = 32'd4;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      if (done) n_done++;
      n++;
      tick();
    end
    if (done) n_done++;
    chk("restart_busy_cycles", 64'(n), 64'd32);
    chk("restart_done_count", 64'(n_done), 64'd1);
    chk("restart_hi", 64'(hi), 64'd0);
    chk("restart_lo", 64'(lo), 64'd8);
    tick();

    // Async reset mid-run discards the operation and clears HI/LO
    run_mul("pre_rst", 32'h0000_FFFF, 32'hAAAA_AAAB, 32'h0000_AAAA, 32'h0000_5555);
    start = 1'b1; a = 32'd11; b = 32'd13;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    n_done = 0;
    repeat (40) begin
      if (done || busy) n_done++;
      tick();
    end
    chk("arst_no_activity", 64'(n_done), 64'd0);
    chk("arst_hi_held", 64'(hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_mult_unit

`default_nettype wire
